// File: rtl/dldo_pkg.sv
// Shared types and helpers for the adaptive digital-LDO controller.
package dldo_pkg;

  typedef enum logic [1:0] {
    COARSE = 2'b00,
    FINE   = 2'b01,
    LOCKED = 2'b10
  } mode_e;

  // Saturating add/subtract; int arithmetic keeps the intermediate free of wrap-around.
  function automatic int clamp_step(input int code, input int step,
                                    input logic up, input int max_code);
    int sum;
    sum = up ? (code + step) : (code - step);
    if (sum < 0)
      return 0;
    if (sum > max_code)
      return max_code;
    return sum;
  endfunction

endpackage

// File: rtl/dldo_therm_dec.sv
// Binary-to-thermometer decoder: out[i] = (i < code).
module dldo_therm_dec #(
  parameter  int PASS_NUM = 16,
  localparam int CNT_W    = $clog2(PASS_NUM + 1)
) (
  input  logic [CNT_W-1:0]    code,
  output logic [PASS_NUM-1:0] out
);

  for (genvar i = 0; i < PASS_NUM; i++) begin : g_bit
    assign out[i] = (code > CNT_W'(i));
  end

endmodule

// File: rtl/dldo_adaptive_ctrl.sv
// Adaptive coarse/fine/locked DLDO pass-device controller.
// Optional macro DLDO_LOCK_HOLD_EN freezes the code while LOCKED.
module dldo_adaptive_ctrl
  import dldo_pkg::*;
#(
  parameter  int PASS_NUM    = 16,
  parameter  int COARSE_STEP = 4,
  parameter  int LOCK_WIN    = 4,
  parameter  int UNLOCK_RUN  = 3,
  localparam int CNT_W       = $clog2(PASS_NUM + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                comp_in,
  output logic [PASS_NUM-1:0] out,
  output logic [CNT_W-1:0]    code,
  output logic [1:0]          mode,
  output logic                locked,
  output logic                sat_hi,
  output logic                sat_lo
);

  localparam int REV_W = $clog2(LOCK_WIN + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);
`ifdef DLDO_LOCK_HOLD_EN
  localparam int LOCKED_STEP = 0;
`else
  localparam int LOCKED_STEP = 1;
`endif

  logic [1:0]       sync_q;
  logic [1:0]       vld_q;
  logic             dir;
  logic             dec_en;
  logic             rev;
  logic [CNT_W-1:0] code_q, code_d;
  mode_e            mode_q, mode_d;
  logic             last_dir, last_vld;
  logic [REV_W-1:0] rev_cnt, rev_d;
  logic [RUN_W-1:0] run_cnt, run_d;
  int               step;

  // Synchronizer plus a fill marker, so decisions start only once real comparator data arrives.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], comp_in};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  assign dir    = sync_q[1];
  assign dec_en = en && vld_q[1];
  assign rev    = last_vld && (dir != last_dir);

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    mode_d = mode_q;
    rev_d  = rev_cnt;
    run_d  = run_cnt;
    step   = 1;
    unique case (mode_q)
      COARSE: begin
        if (rev) begin
          mode_d = FINE;
          rev_d  = REV_W'(1);
        end else begin
          step = COARSE_STEP;
        end
      end
      FINE: begin
        if (rev) begin
          rev_d = rev_cnt + REV_W'(1);
          if (rev_d == REV_W'(LOCK_WIN)) begin
            mode_d = LOCKED;
            run_d  = '0;
          end
        end else begin
          rev_d = '0;
        end
      end
      LOCKED: begin
        step  = LOCKED_STEP;
        run_d = rev ? RUN_W'(1) : run_cnt + RUN_W'(1);
        if (run_d == RUN_W'(UNLOCK_RUN)) begin
          mode_d = COARSE;
          rev_d  = '0;
        end
      end
      default: mode_d = COARSE;
    endcase
    code_d = CNT_W'(clamp_step(int'(code_q), step, dir, PASS_NUM));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q   <= CNT_W'(PASS_NUM);
      mode_q   <= COARSE;
      last_dir <= 1'b0;
      last_vld <= 1'b0;
      rev_cnt  <= '0;
      run_cnt  <= '0;
    end else if (dec_en) begin
      code_q   <= code_d;
      mode_q   <= mode_d;
      last_dir <= dir;
      last_vld <= 1'b1;
      rev_cnt  <= rev_d;
      run_cnt  <= run_d;
    end
  end

  dldo_therm_dec #(.PASS_NUM(PASS_NUM)) u_therm (
    .code (code_q),
    .out  (out)
  );

  assign code   = code_q;
  assign mode   = mode_q;
  assign locked = (mode_q == LOCKED);
  assign sat_hi = (code_q == CNT_W'(PASS_NUM));
  assign sat_lo = (code_q == '0);

endmodule

// File: doc/dldo_adaptive_ctrl.md
Name: dldo_adaptive_ctrl

Overview:
Next-generation digital LDO pass-device controller. It replaces the fixed ±1 thermometer shifter with a binary code register, adaptive coarse/fine stepping, limit-cycle lock detection and saturation flags. It takes the comparator decision each clock and drives a PASS_NUM-wide thermometer enable bus to the pass-transistor array, plus status to the power-management sequencer.

Parameters:
PASS_NUM, 16, number of pass devices (thermometer width), must be >= 4
COARSE_STEP, 4, code step size in COARSE mode, 1 < COARSE_STEP < PASS_NUM
LOCK_WIN, 4, consecutive direction reversals in FINE required to declare lock, >= 2
UNLOCK_RUN, 3, consecutive same-direction decisions in LOCKED that force re-acquisition, >= 2
CNT_W, $clog2(PASS_NUM+1), code width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (asserted when 0)
en  input  1  regulation enable; when low, the code and FSM hold
comp_in  input  1  raw comparator output; 1 means Vout is low (add devices), 0 means Vout is high (remove devices)
out  output  PASS_NUM  thermometer enables, out[i] = (i < code)
code  output  CNT_W  binary count of enabled devices, 0..PASS_NUM
mode  output  2  FSM state (COARSE/FINE/LOCKED encoding)
locked  output  1  high while mode == LOCKED
sat_hi  output  1  code == PASS_NUM
sat_lo  output  1  code == 0

Behaviour:
- comp_in passes through a 2-flop synchronizer that always runs, regardless of en. dir = synced value. The first effect on code is at the 3rd rising edge after comp_in changes.
- Reset (async assert, sync-safe deassert not required here) sets: code = PASS_NUM (out all ones), mode = COARSE, locked = 0, sat_hi = 1, sat_lo = 0, synchronizer = 0, last_dir_valid = 0, reversal and run counters = 0. Reset mid-operation takes effect immediately, without waiting for a clock edge.
- en = 0: code, mode, counters and last_dir hold. Outputs stay stable.
- Step: code_next = clamp(code ± step, 0, PASS_NUM). Use + when dir = 1 and - when dir = 0. Compute at CNT_W+1 bits with no wrap-around. A step blocked by saturation still counts as a decision in dir.
- rev = last_dir_valid && (dir != last_dir). Each enabled cycle sets last_dir <= dir and last_dir_valid <= 1.
- COARSE: step = COARSE_STEP. On rev, that cycle uses step = 1, sets mode <= FINE and rev_cnt <= 1.
- FINE: step = 1. On rev, rev_cnt++. On a non-rev cycle, rev_cnt <= 0. When rev_cnt reaches LOCK_WIN, mode <= LOCKED and run_cnt <= 0. On the transition cycle, a step of 1 is still applied.
- LOCKED: step = 1. On a non-rev cycle, run_cnt++. On rev, run_cnt <= 1. When run_cnt reaches UNLOCK_RUN, mode <= COARSE, locked <= 0, rev_cnt <= 0, and the next step is COARSE_STEP.
- Saturation does not change mode. Holding at PASS_NUM with dir = 1 produces no reversals and stays in the current mode.
- Output timing: out, sat_hi and sat_lo are combinational decodes of the registered code. locked is decoded from registered mode. Latency from synced dir to the out change is one clock.

Optional Feature:
DLDO_LOCK_HOLD_EN
- Defined: in LOCKED, code is frozen at its value on lock entry, so the output stops limit-cycling. The unlock detection via run_cnt still evaluates dir.
- Undefined: in LOCKED, code continues ±1 stepping as described above.

Decomposition:
- Package dldo_pkg holds:
  - mode enum: COARSE = 2'b00, FINE = 2'b01, LOCKED = 2'b10
  - a clamp-add helper function
- Sub-module dldo_therm_dec: parametrised PASS_NUM binary-to-thermometer decoder, purely combinational.
- Synchronizer, FSM and counters stay inline in the top module.

Test Plan:
Use PASS_NUM=16, COARSE_STEP=4, LOCK_WIN=4, UNLOCK_RUN=3 unless noted.
1. Reset low, then high with en=1 and comp_in=1 → out=16'hFFFF, code=16, mode=COARSE, sat_hi=1, sat_lo=0, locked=0; the code holds at 16.
2. comp_in=0 from reset → code goes 16→12→8→4→0 on edges 3..6 after release, then sat_lo=1 and out=16'h0000; mode stays COARSE.
3. From code=8 in COARSE, apply synced dir 0 then 1 → code 4, then 5 with mode=FINE.
4. In FINE, alternate dir 1,0,1,0 → after the 4th reversal locked=1 and mode=LOCKED; the code toggles between two adjacent values (with DLDO_LOCK_HOLD_EN, the code is frozen instead).
5. In LOCKED, hold dir=1 for 3 cycles → mode=COARSE and locked=0; the following steps are +4, clamping at 16.
6. Drop en mid-COARSE at code=12 for 5 cycles with comp toggling → the code stays 12; pulse rst low asynchronously between edges → out=16'hFFFF immediately.
